sr_trace_buffer: RTL and testbench

// - Captures one record per retired instruction (pc, instr, rd write-back) from sr_cpu into a FIFO.
// - Drains records over a valid/ready stream to a downstream consumer: UART dumper, FPGA debug reader or the simulation monitor.
// - Decouples trace collection from consumer speed.
// - Counts dropped records when the consumer stalls.
//

---
 rtl/sr_trace_buffer_pkg.sv | 31 +++
 rtl/sr_trace_fifo.sv | 71 +++++++
 rtl/sr_trace_buffer.sv | 126 ++++++++++++
 tb/tb_sr_trace_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_trace_buffer_pkg.sv
// sr_trace_buffer_pkg: trace record layout (field widths, bit offsets, total width).
// Optional feature macro: SR_TRACE_CYCLE_EN adds a 32-bit cycle stamp field.
package sr_trace_buffer_pkg;

   localparam int PC_W      = 32;
   localparam int INSTR_W   = 32;
   localparam int RD_W      = 5;
   localparam int WE_W      = 1;
   localparam int WD_W      = 32;
   localparam int LOST_W    = 1;

   localparam int PC_OFF    = 0;
   localparam int INSTR_OFF = PC_OFF + PC_W;
   localparam int RD_OFF    = INSTR_OFF + INSTR_W;
   localparam int WE_OFF    = RD_OFF + RD_W;
   localparam int WD_OFF    = WE_OFF + WE_W;
   localparam int LOST_OFF  = WD_OFF + WD_W;

`ifdef SR_TRACE_CYCLE_EN
   localparam int CYCLE_W   = 32;
   localparam int CYCLE_OFF = LOST_OFF + LOST_W;
   localparam int REC_W     = CYCLE_OFF + CYCLE_W;
`else
   localparam int REC_W     = LOST_OFF + LOST_W;
`endif

endpackage

`ifndef SR_TRACE_REC_W
`define SR_TRACE_REC_W sr_trace_buffer_pkg::REC_W
`endif

// File: rtl/sr_trace_fifo.sv
// sr_trace_fifo: generic WIDTH x DEPTH register FIFO, show-ahead read,
// synchronous clear, occupancy level. Read data reads as 0 while empty.
module sr_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   // A pop frees the head slot, so a push into a full FIFO is fine on the same edge.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Next-state for pointers and level; clear wins over push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_d = level_q + 1'b1;
         else if (do_pop && !do_push) level_d = level_q - 1'b1;
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/sr_trace_buffer.sv
// sr_trace_buffer: captures one record per retired instruction into a FIFO,
// drains it over valid/ready, counts records dropped while full.
// Optional feature macro: SR_TRACE_CYCLE_EN (per-record cycle stamp, outCycle port).
module sr_trace_buffer
   import sr_trace_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   trcEn,
   input  logic                   trcClr,
   input  logic                   trcValid,
   input  logic [31:0]            trcPc,
   input  logic [31:0]            trcInstr,
   input  logic [4:0]             trcRd,
   input  logic                   trcWe,
   input  logic [31:0]            trcWd,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [31:0]            outPc,
   output logic [31:0]            outInstr,
   output logic [4:0]             outRd,
   output logic                   outWe,
   output logic [31:0]            outWd,
   output logic                   outLost,
   output logic [$clog2(DEPTH):0] level,
`ifdef SR_TRACE_CYCLE_EN
   output logic [31:0]            outCycle,
`endif
   output logic [CNT_W-1:0]       dropCnt
);

   logic [`SR_TRACE_REC_W-1:0] rec_in, rec_out;
   logic                       full, empty;
   logic                       elig, push, pop, drop;
   logic                       lost_pend_q, lost_pend_d;
   logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;

   assign outValid = ~empty;
   assign pop      = outValid & outReady;
   assign elig     = trcValid & trcEn & ~trcClr;
   assign push     = elig & (~full | pop);
   assign drop     = elig & full & ~pop;
   assign dropCnt  = drop_cnt_q;

`ifdef SR_TRACE_CYCLE_EN
   logic [CYCLE_W-1:0] cycle_q;

   // Free-running stamp counter; flush leaves it alone so stamps stay monotonic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cycle_q <= '0;
      else        cycle_q <= cycle_q + 1'b1;
   end

   assign outCycle = rec_out[CYCLE_OFF +: CYCLE_W];
`endif

   // Pack the incoming record; rd/wd are zeroed for non-writing instructions.
   always_comb begin
      rec_in = '0;
      rec_in[PC_OFF    +: PC_W]    = trcPc;
      rec_in[INSTR_OFF +: INSTR_W] = trcInstr;
      rec_in[RD_OFF    +: RD_W]    = trcWe ? trcRd : '0;
      rec_in[WE_OFF    +: WE_W]    = trcWe;
      rec_in[WD_OFF    +: WD_W]    = trcWe ? trcWd : '0;
      rec_in[LOST_OFF  +: LOST_W]  = lost_pend_q;
`ifdef SR_TRACE_CYCLE_EN
      rec_in[CYCLE_OFF +: CYCLE_W] = cycle_q;
`endif
   end

   // Unpack the head record for the consumer.
   always_comb begin
      outPc    = rec_out[PC_OFF    +: PC_W];
      outInstr = rec_out[INSTR_OFF +: INSTR_W];
      outRd    = rec_out[RD_OFF    +: RD_W];
      outWe    = rec_out[WE_OFF    +: WE_W];
      outWd    = rec_out[WD_OFF    +: WD_W];
      outLost  = rec_out[LOST_OFF  +: LOST_W];
   end

   // Drop accounting: saturating counter and sticky lost marker for the next accepted record.
   always_comb begin
      drop_cnt_d  = drop_cnt_q;
      lost_pend_d = lost_pend_q;
      if (trcClr) begin
         drop_cnt_d  = '0;
         lost_pend_d = 1'b0;
      end else if (drop) begin
         if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
         lost_pend_d = 1'b1;
      end else if (push) begin
         lost_pend_d = 1'b0;
      end
   end

   // Drop accounting registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q  <= '0;
         lost_pend_q <= 1'b0;
      end else begin
         drop_cnt_q  <= drop_cnt_d;
         lost_pend_q <= lost_pend_d;
      end
   end

   sr_trace_fifo #(
      .WIDTH (`SR_TRACE_REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (trcClr),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (rec_in),
      .rdata_o (rec_out),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );

endmodule

// File: tb/tb_sr_trace_buffer.sv
// tb_sr_trace_buffer: directed-vector bench for sr_trace_buffer (DEPTH=16, CNT_W=16).
// Optional feature macro: SR_TRACE_CYCLE_EN enables the cycle-stamp checks.
module tb_sr_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        trcEn, trcClr, trcValid, trcWe;
   logic [31:0] trcPc, trcInstr, trcWd;
   logic [4:0]  trcRd;
   logic        outValid, outReady, outWe, outLost;
   logic [31:0] outPc, outInstr, outWd;
   logic [4:0]  outRd;
   logic [4:0]  level;
   logic [15:0] dropCnt;
`ifdef SR_TRACE_CYCLE_EN
   logic [31:0] outCycle;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sr_trace_buffer #(.DEPTH(16), .CNT_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .trcEn    (trcEn),
      .trcClr   (trcClr),
      .trcValid (trcValid),
      .trcPc    (trcPc),
      .trcInstr (trcInstr),
      .trcRd    (trcRd),
      .trcWe    (trcWe),
      .trcWd    (trcWd),
      .outValid (outValid),
      .outReady (outReady),
      .outPc    (outPc),
      .outInstr (outInstr),
      .outRd    (outRd),
      .outWe    (outWe),
      .outWd    (outWd),
      .outLost  (outLost),
      .level    (level),
`ifdef SR_TRACE_CYCLE_EN
      .outCycle (outCycle),
`endif
      .dropCnt  (dropCnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Advance one clock; afterwards we sit 1 time unit past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rec(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] rd, input logic we, input logic [31:0] wd);
      trcValid = 1'b1;
      trcPc    = pc;
      trcInstr = instr;
      trcRd    = rd;
      trcWe    = we;
      trcWd    = wd;
   endtask

   task automatic drive(input logic [31:0] pc);
      drive_rec(pc, pc ^ 32'hA5A5_0000, pc[6:2], 1'b1, ~pc);
   endtask

   task automatic idle();
      trcValid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; trcEn = 1'b1; trcClr = 1'b0; outReady = 1'b0;
      trcValid = 1'b0; trcPc = '0; trcInstr = '0; trcRd = '0; trcWe = 1'b0; trcWd = '0;

      // Reset state
      step(); step();
      check("rst_valid", outValid, 0);
      check("rst_level", level, 0);
      check("rst_drop",  dropCnt, 0);
      check("rst_pc",    outPc, 0);
      rst_n = 1'b1;
      step();

      // Basic order with a ready consumer
      outReady = 1'b1;
      drive(32'h0); step();
      check("basic_v0", outValid, 1);
      check("basic_pc0", outPc, 32'h0);
      check("basic_lvl0", level, 1);
      drive(32'h4); step();
      check("basic_pc4", outPc, 32'h4);
      check("basic_lvl1", level, 1);
      drive(32'h8); step();
      check("basic_pc8", outPc, 32'h8);
      check("basic_instr8", outInstr, 32'hA5A5_0008);
      idle(); step();
      check("basic_empty", outValid, 0);
      check("basic_lvl_end", level, 0);

      // Fill past capacity with a stalled consumer
      outReady = 1'b0;
      for (int i = 0; i < 19; i++) begin
         drive(32'h100 + 32'(4 * i)); step();
      end
      idle();
      check("fill_level", level, 16);
      check("fill_drop", dropCnt, 3);
      check("fill_hold_pc", outPc, 32'h100);
      outReady = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain_pc%0d", i), outPc, 32'h100 + 32'(4 * i));
         check($sformatf("drain_lost%0d", i), outLost, 0);
         step();
      end
      check("drain_level", level, 0);
      outReady = 1'b0;
      drive(32'h200); step(); idle();
      check("lost_pc", outPc, 32'h200);
      check("lost_flag", outLost, 1);
      outReady = 1'b1; step(); outReady = 1'b0;
      check("lost_popped", level, 0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) begin
         drive(32'h400 + 32'(4 * i)); step();
      end
      check("fs_full", level, 16);
      drive(32'h300); outReady = 1'b1; step(); idle(); outReady = 1'b0;
      check("fs_level", level, 16);
      check("fs_drop", dropCnt, 3);
      check("fs_head", outPc, 32'h404);

      // Clear has priority over a concurrent push
      outReady = 1'b1;
      for (int i = 0; i < 11; i++) step();
      outReady = 1'b0;
      check("clr_pre_level", level, 5);
      trcClr = 1'b1; drive(32'h500); step();
      trcClr = 1'b0; idle();
      check("clr_level", level, 0);
      check("clr_valid", outValid, 0);
      check("clr_drop", dropCnt, 0);
      check("clr_pc", outPc, 0);
      step();
      check("clr_not_stored", level, 0);

      // Field masking
      drive_rec(32'h600, 32'h1234_5678, 5'd7, 1'b0, 32'h55); step(); idle();
      check("mask_rd", outRd, 0);
      check("mask_wd", outWd, 0);
      check("mask_we", outWe, 0);
      check("mask_instr", outInstr, 32'h1234_5678);
      outReady = 1'b1; step(); outReady = 1'b0;
      drive_rec(32'h604, 32'h0000_0013, 5'd7, 1'b1, 32'h55); step(); idle();
      check("wr_rd", outRd, 7);
      check("wr_wd", outWd, 32'h55);
      check("wr_we", outWe, 1);
      outReady = 1'b1; step(); outReady = 1'b0;

      // Capture disabled: nothing stored, but draining still proceeds
      trcEn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(32'h700 + 32'(4 * i)); step();
      end
      idle();
      check("en_level", level, 0);
      check("en_drop", dropCnt, 0);
      trcEn = 1'b1;
      drive(32'h800); step(); drive(32'h804); step();
      check("en_pre_drain", level, 2);
      trcEn = 1'b0; drive(32'h808); outReady = 1'b1;
      step(); step();
      idle(); outReady = 1'b0; trcEn = 1'b1;
      check("en_drained", level, 0);

`ifdef SR_TRACE_CYCLE_EN
      begin
         logic [31:0] c0;
         drive(32'h900); step(); drive(32'h904); step(); idle();
         c0 = outCycle;
         outReady = 1'b1; step(); outReady = 1'b0;
         check("cycle_delta", outCycle - c0, 1);
         outReady = 1'b1; step(); outReady = 1'b0;
      end
`endif

      // Asynchronous reset in the middle of a drain
      for (int i = 0; i < 6; i++) begin
         drive(32'hA00 + 32'(4 * i)); step();
      end
      idle();
      check("ar_level_pre", level, 6);
      outReady = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", outValid, 0);
      check("ar_level", level, 0);
      check("ar_pc", outPc, 0);
      step();
      rst_n = 1'b1; outReady = 1'b0;
      step();
      check("ar_after", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
